pixel_cipher_engine: RTL and testbench

Streaming frame-buffer cipher engine: walks a frame of `FRAME_PIXELS` pixels, reads each pixel from source memory, applies a keyed transform and writes the result to destination memory at the same index. It replaces the single-mode, fixed-size decrypter in the VGA image path. It adds:
- parametrised pixel width, address width and frame size;
- an LFSR keystream XOR mode, which is symmetric, so the same block encrypts and decrypts;
- a start/busy/done handshake;
- a configurable memory read latency.

---
 rtl/pixel_cipher_pkg.sv | 22 ++
 rtl/lfsr_keystream.sv | 24 ++
 rtl/pixel_cipher_engine.sv | 141 ++++++++++++++
 tb/tb_pixel_cipher_engine.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_cipher_pkg.sv
// Shared types and constants for the frame-buffer cipher engine.
package pixel_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_XOR    = 2'd0;
  localparam logic [1:0] MODE_BYPASS = 2'd1;
  localparam logic [1:0] MODE_SUBST  = 2'd2;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// 16-bit right-shifting Galois LFSR keystream; a zero seed falls back to the default
// seed so the register can never lock up at zero.
module lfsr_keystream
  import pixel_cipher_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/pixel_cipher_engine.sv
// Streaming frame cipher: reads each pixel, transforms it and writes it back at the
// same index, one pixel per cycle while active is held.
module pixel_cipher_engine
  import pixel_cipher_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 15,
  parameter int FRAME_PIXELS = 30625,
  parameter int RD_LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [15:0]       key,
  input  logic [DATA_W-1:0] mask,
  input  logic              active,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]      issue_cnt, wr_cnt;
  logic [1:0]            mode_q;
  logic [DATA_W-1:0]     subst_q, mask_q, xformed;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [ADDR_W-1:0]     addr_pipe [RD_LATENCY];
  logic [15:0]           lfsr;
  logic                  start_ok, last_issue, data_vld;
  logic                  unused_lfsr_hi;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign last_issue = rd_en && (issue_cnt == LAST_IDX);
  assign data_vld   = vld_pipe[RD_LATENCY-1];
  assign rd_addr    = issue_cnt[ADDR_W-1:0];
  // Only the low DATA_W keystream bits are used for the XOR.
  assign unused_lfsr_hi = ^lfsr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (last_issue) state_nxt = DRAIN;
      DRAIN:      if (wr_cnt == FRAME_CNT) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      RUN: begin
        busy  = 1'b1;
        rd_en = active && (issue_cnt < FRAME_CNT);
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Valid/address delay line lines each returning read up with its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_pipe[0] <= rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  always_comb begin
    case (mode_q)
      MODE_XOR:   xformed = rd_data ^ lfsr[DATA_W-1:0];
      MODE_SUBST: xformed = ((rd_data & mask_q) == mask_q) ? subst_q : rd_data;
      default:    xformed = rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt <= '0;
      wr_cnt    <= '0;
      mode_q    <= MODE_XOR;
      subst_q   <= '0;
      mask_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= data_vld;
      if (data_vld) begin
        wr_addr <= addr_pipe[RD_LATENCY-1];
        wr_data <= xformed;
        wr_cnt  <= wr_cnt + CNT_W'(1);
      end
      if (rd_en) issue_cnt <= issue_cnt + CNT_W'(1);
      if (start_ok) begin
        issue_cnt <= '0;
        wr_cnt    <= '0;
        mode_q    <= mode;
        subst_q   <= key[DATA_W-1:0];
        mask_q    <= mask;
      end
    end
  end

  // Keystream steps after each written pixel has used the current value.
  lfsr_keystream u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .seed    (key),
    .advance (data_vld),
    .state   (lfsr)
  );

endmodule

// File: tb/tb_pixel_cipher_engine.sv
// Directed bench for pixel_cipher_engine: a 4-pixel/1-latency instance and an
// 8-pixel/3-latency instance, checked against a write scoreboard.
module tb_pixel_cipher_engine;

  localparam int DW  = 8;
  localparam int AW1 = 2;
  localparam int FP1 = 4;
  localparam int AW3 = 3;
  localparam int FP3 = 8;

  typedef struct packed {
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic           start1, active1, rd_en1, wr_en1, busy1, done1;
  logic [1:0]     mode1;
  logic [15:0]    key1;
  logic [DW-1:0]  mask1, wr_data1;
  logic [DW-1:0]  rd_data1 = '0;
  logic [AW1-1:0] rd_addr1, wr_addr1;

  logic           start3, active3, rd_en3, wr_en3, busy3, done3;
  logic [1:0]     mode3;
  logic [15:0]    key3;
  logic [DW-1:0]  mask3, wr_data3, rd_data3;
  logic [AW3-1:0] rd_addr3, wr_addr3;

  logic [DW-1:0] src1 [FP1];
  logic [DW-1:0] dst1 [FP1];
  logic [DW-1:0] orig1 [FP1];
  logic [DW-1:0] src3 [FP3];
  logic [DW-1:0] rpipe3 [3];
  logic [DW-1:0] ks0 [4];

  exp_t exp1 [$];
  exp_t exp3 [$];

  int  n_assert = 0;
  int  n_fail   = 0;
  int  wr_count1 = 0;
  int  wr_count3 = 0;
  int  stray1 = 0;
  bit  sb1_en = 1'b1;
  int  cyc, pw;

  pixel_cipher_engine #(.DATA_W(DW), .ADDR_W(AW1), .FRAME_PIXELS(FP1), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .key(key1), .mask(mask1),
    .active(active1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1), .done(done1)
  );

  pixel_cipher_engine #(.DATA_W(DW), .ADDR_W(AW3), .FRAME_PIXELS(FP3), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode3), .key(key3), .mask(mask3),
    .active(active3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .busy(busy3), .done(done3)
  );

  // Source memories: 1-cycle and 3-cycle read latency.
  always @(posedge clk) if (rd_en1) rd_data1 <= src1[rd_addr1];

  always @(posedge clk) begin
    rpipe3[0] <= src3[rd_addr3];
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end
  assign rd_data3 = rpipe3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [DW-1:0] xf(input logic [1:0] m, input logic [15:0] k,
                                       input logic [DW-1:0] msk, input logic [DW-1:0] d,
                                       input logic [15:0] s);
    case (m)
      2'd0:    return d ^ s[DW-1:0];
      2'd2:    return ((d & msk) == msk) ? k[DW-1:0] : d;
      default: return d;
    endcase
  endfunction

  function automatic exp_t mk(input int a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = 8'(a);
    e.data = d;
    return e;
  endfunction

  task automatic push_model(input int which, input logic [1:0] m, input logic [15:0] k,
                            input logic [DW-1:0] msk);
    logic [15:0] s;
    s = (k == 16'h0000) ? 16'hACE1 : k;
    if (which == 1) begin
      for (int i = 0; i < FP1; i++) begin
        exp1.push_back(mk(i, xf(m, k, msk, src1[i], s)));
        s = lfsr_nx(s);
      end
    end else begin
      for (int i = 0; i < FP3; i++) begin
        exp3.push_back(mk(i, xf(m, k, msk, src3[i], s)));
        s = lfsr_nx(s);
      end
    end
  endtask

  task automatic run1(input logic [1:0] m, input logic [15:0] k, input logic [DW-1:0] msk,
                      output int c);
    mode1 = m; key1 = k; mask1 = msk; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    c = 1;
    while (!done1 && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic frame_end1(input string tag, input int c);
    chk({tag, "_cycles"}, c, 7);
    chk({tag, "_writes"}, wr_count1, FP1);
    chk({tag, "_sb_left"}, exp1.size(), 0);
  endtask

  // Scoreboard monitors, sampled just after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      chk("busy_done_excl1", {31'b0, busy1 & done1}, 0);
      if (wr_en1) begin
        wr_count1++;
        dst1[wr_addr1] = wr_data1;
        if (!sb1_en) stray1++;
        else if (exp1.size() == 0) chk("sb1_extra_write", exp1.size(), 1);
        else begin
          e = exp1.pop_front();
          chk("wr_addr1", wr_addr1, e.addr);
          chk("wr_data1", wr_data1, e.data);
        end
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      chk("busy_done_excl3", {31'b0, busy3 & done3}, 0);
      if (wr_en3) begin
        wr_count3++;
        if (exp3.size() == 0) chk("sb3_extra_write", exp3.size(), 1);
        else begin
          e = exp3.pop_front();
          chk("wr_addr3", wr_addr3, e.addr);
          chk("wr_data3", wr_data3, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ks0[0] = 8'hE1; ks0[1] = 8'h70; ks0[2] = 8'h38; ks0[3] = 8'h9C;
    reset = 1'b1;
    start1 = 1'b0; active1 = 1'b1; mode1 = 2'd0; key1 = 16'h0; mask1 = '0;
    start3 = 1'b0; active3 = 1'b1; mode3 = 2'd0; key3 = 16'h0; mask3 = '0;
    for (int i = 0; i < FP1; i++) begin src1[i] = '0; dst1[i] = '0; end
    for (int i = 0; i < FP3; i++) src3[i] = DW'($urandom);
    repeat (3) @(negedge clk);

    chk("rst_rd_en", rd_en1, 0);
    chk("rst_wr_en", wr_en1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rd_addr", rd_addr1, 0);
    chk("rst_wr_addr", wr_addr1, 0);
    chk("rst_wr_data", wr_data1, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_done3", done3, 0);
    reset = 1'b0;
    @(negedge clk);

    // XOR keystream over an all-zero frame with the default seed.
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, ks0[i]));
    wr_count1 = 0;
    run1(2'd0, 16'h0000, '0, cyc);
    frame_end1("xor_zero", cyc);
    repeat (3) @(negedge clk);
    chk("done_held", done1, 1);
    chk("busy_after_done", busy1, 0);

    // Feed the ciphertext back: plaintext must return.
    for (int i = 0; i < FP1; i++) begin orig1[i] = src1[i]; src1[i] = dst1[i]; end
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, orig1[i]));
    wr_count1 = 0;
    run1(2'd0, 16'h0000, '0, cyc);
    frame_end1("xor_back0", cyc);

    for (int i = 0; i < FP1; i++) begin src1[i] = DW'($urandom); orig1[i] = src1[i]; end
    push_model(1, 2'd0, 16'h1234, '0);
    wr_count1 = 0;
    run1(2'd0, 16'h1234, '0, cyc);
    frame_end1("xor_key", cyc);
    for (int i = 0; i < FP1; i++) src1[i] = dst1[i];
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, orig1[i]));
    wr_count1 = 0;
    run1(2'd0, 16'h1234, '0, cyc);
    frame_end1("xor_key_back", cyc);

    // Masked substitute.
    src1[0] = 8'h7F; src1[1] = 8'h10; src1[2] = 8'h78; src1[3] = 8'hF8;
    exp1.push_back(mk(0, 8'hAA));
    exp1.push_back(mk(1, 8'h10));
    exp1.push_back(mk(2, 8'hAA));
    exp1.push_back(mk(3, 8'hAA));
    wr_count1 = 0;
    run1(2'd2, 16'h00AA, 8'h78, cyc);
    frame_end1("subst", cyc);

    // Bypass and reserved mode both copy unchanged.
    for (int i = 0; i < FP1; i++) src1[i] = DW'($urandom);
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, src1[i]));
    wr_count1 = 0;
    run1(2'd1, 16'h1234, 8'hFF, cyc);
    frame_end1("bypass", cyc);
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, src1[i]));
    wr_count1 = 0;
    run1(2'd3, 16'h1234, 8'hFF, cyc);
    frame_end1("reserved", cyc);

    // Reset while pixel 2 is being read: nothing further may be written.
    sb1_en = 1'b0;
    mode1 = 2'd0; key1 = 16'h0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!(rd_en1 && rd_addr1 == 2'd2) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached_px2", {31'b0, rd_en1 && rd_addr1 == 2'd2}, 1);
    reset = 1'b1;
    stray1 = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_done", done1, 0);
    chk("rst_mid_wr_en", wr_en1, 0);
    repeat (8) @(negedge clk);
    chk("rst_mid_stray_writes", stray1, 0);
    sb1_en = 1'b1;
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, src1[i] ^ ks0[i]));
    wr_count1 = 0;
    run1(2'd0, 16'h0000, '0, cyc);
    frame_end1("after_rst", cyc);

    // A second start during RUN must not restart the frame or reseed.
    for (int i = 0; i < FP1; i++) src1[i] = DW'($urandom);
    for (int i = 0; i < FP1; i++) exp1.push_back(mk(i, src1[i] ^ ks0[i]));
    wr_count1 = 0;
    mode1 = 2'd0; key1 = 16'h0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    mode1 = 2'd1; key1 = 16'h5555; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 3;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    frame_end1("start_in_run", cyc);

    // Latency-3 instance, issue paused for 5 cycles after 3 reads.
    push_model(3, 2'd0, 16'hBEEF, '0);
    wr_count3 = 0;
    mode3 = 2'd0; key3 = 16'hBEEF; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 1;
    pw = 0;
    while (!done3 && cyc < 300) begin
      if (cyc >= 5 && cyc <= 9) begin
        if (wr_en3) pw++;
        chk("pause_no_issue", rd_en3, 0);
      end
      active3 = !(cyc >= 4 && cyc <= 8);
      @(negedge clk);
      cyc++;
    end
    active3 = 1'b1;
    chk("pause_cycles", cyc, 18);
    chk("pause_inflight_writes", pw, 3);
    chk("pause_writes", wr_count3, FP3);
    chk("pause_sb_left", exp3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
